// File: rtl/soc_rtc_pkg.sv
// Shared constants for the SoC RTC: register word addresses, CTRL/STATUS bit positions, alarm bound.
package soc_rtc_pkg;

    localparam int unsigned MAX_ALARMS    = 8;
    localparam int unsigned ADDR_W        = 5;

    localparam int unsigned ADDR_CTRL     = 0;
    localparam int unsigned ADDR_PRESC    = 1;
    localparam int unsigned ADDR_COUNT    = 2;
    localparam int unsigned ADDR_STATUS   = 3;
    localparam int unsigned ADDR_CMP_BASE = 4;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_OVF_IE   = 1;
    localparam int unsigned CTRL_ALM_EN   = 8;
    localparam int unsigned CTRL_ALM_IE   = 16;

    localparam int unsigned STAT_OVF      = 0;
    localparam int unsigned STAT_ALM      = 8;

    // Channel k owns an interleaved CMP/PERIOD address pair.
    function automatic logic [ADDR_W-1:0] cmp_addr(input int unsigned k);
        return ADDR_W'(ADDR_CMP_BASE + 2 * k);
    endfunction

    function automatic logic [ADDR_W-1:0] period_addr(input int unsigned k);
        return ADDR_W'(ADDR_CMP_BASE + 2 * k + 1);
    endfunction

endpackage

// File: rtl/soc_rtc_alarm_ch.sv
// One RTC alarm channel: CMP/PERIOD registers, match comparator and reload.
// Periodic reload exists only when SOC_RTC_PERIODIC_EN is defined.
module soc_rtc_alarm_ch #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              count_wr,
    input  logic              alm_en,
    input  logic [DATA_W-1:0] count_next,
    input  logic              cmp_we,
    input  logic              period_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] cmp,
    output logic [DATA_W-1:0] period,
    output logic              match_pulse,
    output logic              clear_en
);

    // A software COUNT write suppresses evaluation on that tick.
    assign match_pulse = alm_en & tick & ~count_wr & (count_next == cmp);

`ifdef SOC_RTC_PERIODIC_EN
    logic reload;

    assign reload   = match_pulse & (period != '0);
    assign clear_en = match_pulse & ~reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
        end else if (period_we) begin
            period <= wdata;
        end
    end

    // A bus write to CMP replaces any reload in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= '0;
        end else if (cmp_we) begin
            cmp <= wdata;
        end else if (reload) begin
            cmp <= cmp + period;
        end
    end
`else
    logic unused_period_we;

    assign unused_period_we = period_we;
    assign period           = '0;
    assign clear_en         = match_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= '0;
        end else if (cmp_we) begin
            cmp <= wdata;
        end
    end
`endif

endmodule

// File: rtl/soc_rtc_alarm.sv
// SoC RTC top: prescaler, COUNT, CTRL, sticky STATUS, bus decode and interrupt.
// Define SOC_RTC_PERIODIC_EN to build periodic alarm reload.
module soc_rtc_alarm
    import soc_rtc_pkg::*;
#(
    parameter int unsigned IO_MAP_WIDTH = 32,
    parameter int unsigned NUM_ALARMS   = 4,
    parameter int unsigned PRESC_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              rtc_addr,
    input  logic                    rtc_re,
    input  logic                    rtc_we,
    input  logic [IO_MAP_WIDTH-1:0] rtc_wdata,
    output logic [IO_MAP_WIDTH-1:0] rtc_rdata,
    output logic                    rtc_ready,
    output logic                    rtc_irq
);

    localparam int unsigned DW = IO_MAP_WIDTH;
    localparam int unsigned NA = NUM_ALARMS;

    logic                   en;
    logic                   ovf_ie;
    logic [NA-1:0]          alm_en;
    logic [NA-1:0]          alm_ie;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [DW-1:0]          count;
    logic                   ovf;
    logic [NA-1:0]          alm;

    logic          wr_ctrl, wr_presc, wr_count, wr_status;
    logic          tick, ovf_set, ovf_w1c;
    logic [NA-1:0] alm_w1c, match, clear, cmp_we, per_we;
    logic [DW-1:0] count_next, rd_mux;
    logic [DW-1:0] cmp_val [NA];
    logic [DW-1:0] per_val [NA];

    assign wr_ctrl    = rtc_we && (rtc_addr == ADDR_W'(ADDR_CTRL));
    assign wr_presc   = rtc_we && (rtc_addr == ADDR_W'(ADDR_PRESC));
    assign wr_count   = rtc_we && (rtc_addr == ADDR_W'(ADDR_COUNT));
    assign wr_status  = rtc_we && (rtc_addr == ADDR_W'(ADDR_STATUS));

    assign tick       = en && (presc_cnt == presc);
    assign count_next = count + DW'(1);
    assign ovf_set    = tick && !wr_count && (count == '1);
    assign ovf_w1c    = wr_status && rtc_wdata[STAT_OVF];
    assign alm_w1c    = wr_status ? rtc_wdata[STAT_ALM +: NA] : '0;

    for (genvar g = 0; g < NA; g++) begin : g_ch
        assign cmp_we[g] = rtc_we && (rtc_addr == cmp_addr(g));
        assign per_we[g] = rtc_we && (rtc_addr == period_addr(g));

        soc_rtc_alarm_ch #(.DATA_W(DW)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .count_wr    (wr_count),
            .alm_en      (alm_en[g]),
            .count_next  (count_next),
            .cmp_we      (cmp_we[g]),
            .period_we   (per_we[g]),
            .wdata       (rtc_wdata),
            .cmp         (cmp_val[g]),
            .period      (per_val[g]),
            .match_pulse (match[g]),
            .clear_en    (clear[g])
        );
    end

    // Prescaler restarts on PRESC write and idles at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else begin
            if (wr_presc) begin
                presc <= rtc_wdata[PRESC_WIDTH-1:0];
            end
            if (wr_presc || !en || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= rtc_wdata;
        end else if (tick) begin
            count <= count_next;
        end
    end

    // CTRL write beats a same-cycle one-shot clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            ovf_ie <= 1'b0;
            alm_en <= '0;
            alm_ie <= '0;
        end else if (wr_ctrl) begin
            en     <= rtc_wdata[CTRL_EN];
            ovf_ie <= rtc_wdata[CTRL_OVF_IE];
            alm_en <= rtc_wdata[CTRL_ALM_EN +: NA];
            alm_ie <= rtc_wdata[CTRL_ALM_IE +: NA];
        end else begin
            alm_en <= alm_en & ~clear;
        end
    end

    // Sticky status: hardware set beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            alm <= '0;
        end else begin
            ovf <= (ovf & ~ovf_w1c) | ovf_set;
            alm <= (alm & ~alm_w1c) | match;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rtc_addr)
            ADDR_W'(ADDR_CTRL): begin
                rd_mux[CTRL_EN]            = en;
                rd_mux[CTRL_OVF_IE]        = ovf_ie;
                rd_mux[CTRL_ALM_EN +: NA]  = alm_en;
                rd_mux[CTRL_ALM_IE +: NA]  = alm_ie;
            end
            ADDR_W'(ADDR_PRESC):  rd_mux = DW'(presc);
            ADDR_W'(ADDR_COUNT):  rd_mux = count;
            ADDR_W'(ADDR_STATUS): begin
                rd_mux[STAT_OVF]       = ovf;
                rd_mux[STAT_ALM +: NA] = alm;
            end
            default: ;
        endcase
        for (int unsigned k = 0; k < NA; k++) begin
            if (rtc_addr == cmp_addr(k)) begin
                rd_mux = cmp_val[k];
            end
            if (rtc_addr == period_addr(k)) begin
                rd_mux = per_val[k];
            end
        end
    end

    // Read data reflects pre-write state when re and we coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtc_rdata <= '0;
            rtc_ready <= 1'b0;
            rtc_irq   <= 1'b0;
        end else begin
            rtc_rdata <= rtc_re ? rd_mux : '0;
            rtc_ready <= rtc_re | rtc_we;
            rtc_irq   <= (|(alm & alm_ie)) | (ovf & ovf_ie);
        end
    end

endmodule

// File: tb/tb_soc_rtc_alarm.sv
// Self-checking bench for soc_rtc_alarm: register table, directed corner sequences, random vs model.
module tb_soc_rtc_alarm;

    localparam int unsigned NA = 4;
`ifdef SOC_RTC_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif
    localparam bit [7:0] AMASK = 8'((1 << NA) - 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rtc_addr;
    logic        rtc_re;
    logic        rtc_we;
    logic [31:0] rtc_wdata;
    logic [31:0] rtc_rdata;
    logic        rtc_ready;
    logic        rtc_irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_rtc_alarm #(.IO_MAP_WIDTH(32), .NUM_ALARMS(NA), .PRESC_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rtc_addr  (rtc_addr),
        .rtc_re    (rtc_re),
        .rtc_we    (rtc_we),
        .rtc_wdata (rtc_wdata),
        .rtc_rdata (rtc_rdata),
        .rtc_ready (rtc_ready),
        .rtc_irq   (rtc_irq)
    );

    // Reference model state, kept as plain architectural values
    bit          m_en, m_ovf_ie, m_ovf, m_ready, m_irq;
    bit [7:0]    m_alm_en, m_alm_ie, m_alm;
    bit [31:0]   m_presc, m_pcnt, m_count, m_rdata;
    bit [31:0]   m_cmp [NA];
    bit [31:0]   m_per [NA];

    typedef struct {
        bit        re;
        bit        we;
        bit [4:0]  addr;
        bit [31:0] wdata;
        bit [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [4:0] a);
        bit [31:0] v = '0;
        int idx;
        if (a == 5'd0) begin
            v[0] = m_en; v[1] = m_ovf_ie; v[15:8] = m_alm_en; v[23:16] = m_alm_ie;
        end else if (a == 5'd1) v = m_presc;
        else if (a == 5'd2) v = m_count;
        else if (a == 5'd3) begin
            v[0] = m_ovf; v[15:8] = m_alm;
        end else if (a >= 5'd4 && int'(a) < 4 + 2 * NA) begin
            idx = (int'(a) - 4) / 2;
            v = a[0] ? (PERIODIC ? m_per[idx] : 32'h0) : m_cmp[idx];
        end
        return v;
    endfunction

    task automatic m_reset();
        m_en = 0; m_ovf_ie = 0; m_ovf = 0; m_ready = 0; m_irq = 0;
        m_alm_en = 0; m_alm_ie = 0; m_alm = 0;
        m_presc = 0; m_pcnt = 0; m_count = 0; m_rdata = 0;
        for (int k = 0; k < NA; k++) begin
            m_cmp[k] = 0; m_per[k] = 0;
        end
    endtask

    // One clock edge of the RTC: everything is judged from pre-edge state, then writes land.
    task automatic m_step(input bit re, input bit we, input bit [4:0] a, input bit [31:0] d);
        bit tick, cw, ovf_set;
        bit [31:0] nxt;
        bit [7:0] hit = '0;
        int idx;
        m_ready = re | we;
        m_rdata = re ? m_read(a) : 32'h0;
        m_irq   = (m_ovf && m_ovf_ie) || ((m_alm & m_alm_ie) != 0);
        tick    = m_en && (m_pcnt == m_presc);
        cw      = we && (a == 5'd2);
        nxt     = m_count + 1;
        ovf_set = tick && !cw && (m_count == 32'hFFFF_FFFF);
        for (int k = 0; k < NA; k++) begin
            if (m_alm_en[k] && tick && !cw && nxt == m_cmp[k]) begin
                hit[k] = 1'b1;
                if (PERIODIC && m_per[k] != 0) m_cmp[k] = m_cmp[k] + m_per[k];
                else m_alm_en[k] = 1'b0;
            end
        end
        if ((we && a == 5'd1) || !m_en || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (cw) m_count = d;
        else if (tick) m_count = nxt;
        if (we) begin
            if (a == 5'd0) begin
                m_en = d[0]; m_ovf_ie = d[1];
                m_alm_en = d[15:8] & AMASK; m_alm_ie = d[23:16] & AMASK;
            end else if (a == 5'd1) m_presc = {16'h0, d[15:0]};
            else if (a == 5'd3) begin
                if (d[0]) m_ovf = 0;
                m_alm = m_alm & ~d[15:8];
            end else if (a >= 5'd4 && int'(a) < 4 + 2 * NA) begin
                idx = (int'(a) - 4) / 2;
                if (!a[0]) m_cmp[idx] = d;
                else if (PERIODIC) m_per[idx] = d;
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        m_alm = m_alm | hit;
    endtask

    task automatic cyc(input bit re, input bit we, input bit [4:0] a, input bit [31:0] d,
                       output bit [31:0] rd);
        rtc_re = re; rtc_we = we; rtc_addr = a; rtc_wdata = d;
        @(posedge clk);
        m_step(re, we, a, d);
        #1;
        check("ready", rtc_ready, m_ready);
        check("irq", rtc_irq, m_irq);
        if (re) check("rdata", rtc_rdata, m_rdata);
        rd = rtc_rdata;
        rtc_re = 0; rtc_we = 0;
    endtask

    task automatic wr(input bit [4:0] a, input bit [31:0] d);
        bit [31:0] v;
        cyc(1'b0, 1'b1, a, d, v);
    endtask

    task automatic rd(input bit [4:0] a, output bit [31:0] v);
        cyc(1'b1, 1'b0, a, 32'h0, v);
    endtask

    task automatic idle(input int n);
        bit [31:0] v;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, v);
    endtask

    task automatic do_reset();
        rtc_re = 0; rtc_we = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdata", rtc_rdata, 32'h0);
        check("rst_ready", rtc_ready, 32'h0);
        check("rst_irq", rtc_irq, 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t      tbl[$];
        vec_t      t;
        bit [31:0] v;
        bit [31:0] hits;
        bit [4:0]  a;
        bit        re, we;

        rst_n = 1'b0; rtc_re = 0; rtc_we = 0; rtc_addr = 0; rtc_wdata = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Register map walk with the counter disabled
        tbl.push_back('{1'b1, 1'b0, 5'd0,  32'h0,          32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd1,  32'h0,          32'h0});
        tbl.push_back('{1'b0, 1'b1, 5'd1,  32'h0001_2345,  32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd1,  32'h0,          32'h0000_2345});
        tbl.push_back('{1'b0, 1'b1, 5'd0,  32'hFFFF_FFFE,  32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd0,  32'h0,          32'h000F_0F02});
        tbl.push_back('{1'b0, 1'b1, 5'd6,  32'hDEAD_BEEF,  32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd6,  32'h0,          32'hDEAD_BEEF});
        tbl.push_back('{1'b0, 1'b1, 5'd7,  32'h55,         32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd7,  32'h0,          PERIODIC ? 32'h55 : 32'h0});
        tbl.push_back('{1'b0, 1'b1, 5'd12, 32'h1234,       32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd12, 32'h0,          32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd31, 32'h0,          32'h0});
        tbl.push_back('{1'b0, 1'b1, 5'd2,  32'h100,        32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd2,  32'h0,          32'h100});
        tbl.push_back('{1'b1, 1'b0, 5'd3,  32'h0,          32'h0});
        tbl.push_back('{1'b1, 1'b1, 5'd6,  32'h77,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, 1'b0, 5'd6,  32'h0,          32'h77});
        tbl.push_back('{1'b0, 1'b1, 5'd0,  32'h0,          32'h0});
        tbl.push_back('{1'b1, 1'b0, 5'd0,  32'h0,          32'h0});
        foreach (tbl[i]) begin
            t = tbl[i];
            cyc(t.re, t.we, t.addr, t.wdata, v);
            if (t.re) check($sformatf("tbl%0d", i), v, t.exp);
        end

        // Prescale by 4: ten ticks land before a read strobed 41 cycles after enable
        do_reset();
        wr(5'd1, 32'd3);
        wr(5'd0, 32'h1);
        idle(40);
        rd(5'd2, v);
        check("presc_count", v, 32'd10);

        // One-shot alarm with interrupt
        do_reset();
        wr(5'd4, 32'd5);
        wr(5'd5, 32'd0);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'h0001_0101);
        idle(5);
        check("oneshot_irq_early", rtc_irq, 32'h0);
        idle(1);
        check("oneshot_irq", rtc_irq, 32'h1);
        rd(5'd3, v);
        check("oneshot_status", v, 32'h100);
        rd(5'd0, v);
        check("oneshot_ctrl", v, 32'h0001_0001);
        wr(5'd3, 32'h100);
        check("w1c_irq_hold", rtc_irq, 32'h1);
        idle(1);
        check("w1c_irq_low", rtc_irq, 32'h0);

        // Periodic reload: read-and-clear STATUS each cycle, record which counts matched
        do_reset();
        wr(5'd4, 32'd3);
        wr(5'd5, 32'd4);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'h101);
        hits = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b1, 1'b1, 5'd3, 32'h100, v);
            if (v[8]) hits[i-1] = 1'b1;
        end
        check("periodic_hits", hits, PERIODIC ? 32'h888 : 32'h8);
        rd(5'd4, v);
        check("periodic_cmp", v, PERIODIC ? 32'd15 : 32'd3);

        // Collision: W1C in the match cycle loses to the set
        do_reset();
        wr(5'd4, 32'd5);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'h0001_0101);
        idle(4);
        wr(5'd3, 32'h100);
        rd(5'd3, v);
        check("coll_status", v, 32'h100);
        idle(1);
        check("coll_irq", rtc_irq, 32'h1);

        // Counter wrap raises OVF
        do_reset();
        wr(5'd2, 32'hFFFF_FFFE);
        wr(5'd1, 32'd0);
        wr(5'd0, 32'h3);
        idle(2);
        rd(5'd2, v);
        check("wrap_count", v, 32'h0);
        check("wrap_irq", rtc_irq, 32'h1);
        rd(5'd3, v);
        check("wrap_status", v, 32'h1);

        // Reset in the middle of running operation
        do_reset();
        rd(5'd2, v);
        check("post_rst_count", v, 32'h0);
        rd(5'd0, v);
        check("post_rst_ctrl", v, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            a  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
            re = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) == 0);
            case (a)
                5'd0: begin
                    v = $urandom;
                    v[0] = ($urandom_range(0, 3) != 0);
                end
                5'd1: v = $urandom_range(0, 3);
                5'd2: v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 30))
                                                     : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                5'd4, 5'd6, 5'd8, 5'd10: v = $urandom_range(0, 40);
                5'd5, 5'd7, 5'd9, 5'd11: v = $urandom_range(0, 8);
                default: v = $urandom;
            endcase
            cyc(re, we, a, v, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
